// File: rtl/alu_seq_core.sv
// Purpose : multi-cycle signed ALU (add/sub/mul/div/and/or/xor), WIDTH-bit operands, 2*WIDTH-bit result.
// Latency : done pulses in the cycle after edge k+N (k = edge that samples start); N=1, or WIDTH for mul/div.
// Backpr. : start/done handshake; start is ignored while busy, and is accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   start, op         request strobe and opcode (000 add .. 110 xor, 111 reserved)
//   in_a, in_b        signed operands (dividend / divisor for div)
//   result            signed 2*WIDTH-bit result, held until the next done
//   remainder         signed remainder for div, 0 for all other ops
//   busy, done        operation in flight / one-cycle completion pulse
//   err_div0          div with in_b==0; cleared by the next accepted start
//   flags[3:0]        {N,Z,C,V}, only present when ALU_FLAGS_EN is defined
//
// Optional feature macro: ALU_FLAGS_EN (adds the flags port and its logic).

module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 err_div0
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);

  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Architectural state
  state_t          state_q;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            neg_q;     // operand signs differ: sign of product / quotient
  logic [W-1:0]    m_q;       // multiplicand (mul) or divisor (div) magnitude
  logic [W2-1:0]   acc_q;     // mul: {partial product, multiplier}; div: {partial remainder, quotient}
  logic [CW-1:0]   cnt_q;     // EXEC edges still to go after the current one
  logic [W2-1:0]   result_q;
  logic [W-1:0]    rem_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  // Combinational helpers
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [W:0]      mul_sum;
  logic [W2-1:0]   mul_acc;
  logic [W:0]      div_rs;
  logic            div_fit;
  logic [W:0]      div_diff;
  logic [W2-1:0]   div_acc;
  logic [W2-1:0]   step_acc;
  logic [W2-1:0]   a_ext;
  logic [W2-1:0]   b_ext;
  logic [W2-1:0]   quo_ext;
  logic [W-1:0]    rmag;
  logic [W2-1:0]   res_d;
  logic [W-1:0]    rem_d;
  logic            err_d;
  logic            iter_op;   // op at the input needs WIDTH iterations
  logic            unused_bits;

`ifdef ALU_FLAGS_EN
  logic [3:0]      flags_q;
  logic [3:0]      flags_d;
  logic [W:0]      add_u;
`endif

  always_comb begin
    // Magnitudes of the incoming operands; -2^(W-1) maps to 2^(W-1) as unsigned.
    a_mag   = in_a[W-1] ? -in_a : in_a;
    b_mag   = in_b[W-1] ? -in_b : in_b;
    iter_op = (op == OP_MUL) || ((op == OP_DIV) && (in_b != '0));

    // Shift-add multiply step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    mul_sum = {1'b0, acc_q[W2-1:W]} + {1'b0, m_q & {W{acc_q[0]}}};
    mul_acc = {mul_sum, acc_q[W-1:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, record the quotient bit.
    // The remainder stays below the divisor (<= 2^(W-1)), so W bits hold it.
    div_rs   = {acc_q[W2-1:W], acc_q[W-1]};
    div_fit  = div_rs >= {1'b0, m_q};
    div_diff = div_rs - {1'b0, m_q};
    div_acc  = {(div_fit ? div_diff[W-1:0] : div_rs[W-1:0]), acc_q[W-2:0], div_fit};

    step_acc = (op_q == OP_MUL) ? mul_acc : div_acc;

    a_ext   = {{W{a_q[W-1]}}, a_q};
    b_ext   = {{W{b_q[W-1]}}, b_q};
    quo_ext = {{W{1'b0}}, div_acc[W-1:0]};
    rmag    = div_acc[W2-1:W];

    // Final values, used on the last EXEC edge. For mul/div they come from the
    // last iteration's step output so no extra cycle is needed for sign fix-up.
    res_d = '0;
    rem_d = '0;
    err_d = 1'b0;
    case (op_q)
      OP_ADD: res_d = a_ext + b_ext;
      OP_SUB: res_d = a_ext - b_ext;
      OP_MUL: res_d = neg_q ? -mul_acc : mul_acc;
      OP_DIV: begin
        if (b_q == '0) begin
          rem_d = a_q;
          err_d = 1'b1;
        end else begin
          res_d = neg_q ? -quo_ext : quo_ext;
          rem_d = a_q[W-1] ? -rmag : rmag;   // remainder follows the dividend sign
        end
      end
      OP_AND: res_d = {{W{1'b0}}, a_q & b_q};
      OP_OR:  res_d = {{W{1'b0}}, a_q | b_q};
      OP_XOR: res_d = {{W{1'b0}}, a_q ^ b_q};
      default: begin
        res_d = '0;
      end
    endcase

`ifdef ALU_FLAGS_EN
    add_u      = {1'b0, a_q} + {1'b0, b_q};
    flags_d    = '0;
    flags_d[3] = res_d[W2-1];
    flags_d[2] = (res_d == '0);
    case (op_q)
      OP_ADD: begin
        flags_d[1] = add_u[W];
        // The exact (W+1)-bit sum overflows W bits when its top two bits differ.
        flags_d[0] = res_d[W] != res_d[W-1];
      end
      OP_SUB: begin
        flags_d[1] = a_q < b_q;
        flags_d[0] = res_d[W] != res_d[W-1];
      end
      OP_MUL: begin
        flags_d[0] = res_d != {{W{res_d[W-1]}}, res_d[W-1:0]};
      end
      default: begin
        flags_d[1:0] = 2'b00;
      end
    endcase
`endif
  end

`ifdef ALU_FLAGS_EN
  assign unused_bits = ^{div_diff[W], add_u[W-1:0]};
`else
  assign unused_bits = div_diff[W];
`endif

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_q     <= in_a;
            b_q     <= in_b;
            neg_q   <= in_a[W-1] ^ in_b[W-1];
            m_q     <= (op == OP_MUL) ? a_mag : b_mag;
            acc_q   <= {{W{1'b0}}, ((op == OP_MUL) ? b_mag : a_mag)};
            cnt_q   <= iter_op ? CW'(W - 1) : '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_EXEC: begin
          acc_q <= step_acc;
          if (cnt_q == '0) begin
            result_q <= res_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
`ifdef ALU_FLAGS_EN
            flags_q  <= flags_d;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_div0  = err_q;
`ifdef ALU_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] result;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        err_div0;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .result    (result),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err_div0  (err_div0)
`ifdef ALU_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  // Reference model: plain integer arithmetic on the signed operand values.
  function automatic void model(input logic [2:0] o, input logic [7:0] a8, input logic [7:0] b8,
                                output logic [15:0] r, output logic [7:0] rm, output logic e,
                                output int n, output logic [3:0] fl);
    int a, b, x, rmi;
    logic c, v;
    a = int'($signed(a8));
    b = int'($signed(b8));
    x = 0; rmi = 0; e = 1'b0; n = 1; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: begin x = a + b; c = (int'(a8) + int'(b8)) > 255; v = (x > 127) || (x < -128); end
      3'd1: begin x = a - b; c = a8 < b8;                    v = (x > 127) || (x < -128); end
      3'd2: begin x = a * b; n = W;                           v = (x > 127) || (x < -128); end
      3'd3: begin
        if (b == 0) begin rmi = a; e = 1'b1; end
        else begin x = a / b; rmi = a % b; n = W; end
      end
      3'd4: x = int'(a8 & b8);
      3'd5: x = int'(a8 | b8);
      3'd6: x = int'(a8 ^ b8);
      default: x = 0;
    endcase
    r  = x[15:0];
    rm = rmi[7:0];
    fl = {r[15], (r == 16'h0), c, v};
  endfunction

  // Issues one operation starting #1 after an edge; returns #1 after the done
  // edge. lat = edges after the sampling edge until done (-1 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt, output logic [15:0] r,
                        output logic [7:0] rm, output logic e, output logic [3:0] fl);
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) bcnt++;
      op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    r = result; rm = remainder; e = err_div0;
`ifdef ALU_FLAGS_EN
    fl = flags;
`else
    fl = 4'h0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (result !== 16'h0)     begin bad++; $display("FAIL reset result: got %h want 0000", result); end
    total++; if (remainder !== 8'h0)   begin bad++; $display("FAIL reset remainder: got %h want 00", remainder); end
    total++; if (err_div0 !== 1'b0)    begin bad++; $display("FAIL reset err_div0: got %b want 0", err_div0); end
`ifdef ALU_FLAGS_EN
    total++; if (flags !== 4'h0)       begin bad++; $display("FAIL reset flags: got %h want 0", flags); end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    logic [7:0]  rm;
    logic        e;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    int lat, bcnt;
    logic [15:0] r; logic [7:0] rm; logic e; logic [3:0] fl;
    v[0] = '{3'd0, 8'd100, 8'd50, 16'h0096, 8'h00, 1'b0, 1};
    v[1] = '{3'd1, 8'h80,  8'h01, 16'hFF7F, 8'h00, 1'b0, 1};
    v[2] = '{3'd2, 8'hF9,  8'h0C, 16'hFFAC, 8'h00, 1'b0, 8};
    v[3] = '{3'd2, 8'h80,  8'h80, 16'h4000, 8'h00, 1'b0, 8};
    v[4] = '{3'd3, 8'h9C,  8'h07, 16'hFFF2, 8'hFE, 1'b0, 8};
    v[5] = '{3'd3, 8'h05,  8'h00, 16'h0000, 8'h05, 1'b1, 1};
    v[6] = '{3'd3, 8'h80,  8'hFF, 16'h0080, 8'h00, 1'b0, 8};
    v[7] = '{3'd6, 8'hF0,  8'h3C, 16'h00CC, 8'h00, 1'b0, 1};
    v[8] = '{3'd7, 8'h12,  8'h34, 16'h0000, 8'h00, 1'b0, 1};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].o, v[i].a, v[i].b, lat, bcnt, r, rm, e, fl);
      total++; if (r !== v[i].r)    begin bad++; $display("FAIL dir%0d result: got %h want %h", i, r, v[i].r); end
      total++; if (rm !== v[i].rm)  begin bad++; $display("FAIL dir%0d remainder: got %h want %h", i, rm, v[i].rm); end
      total++; if (e !== v[i].e)    begin bad++; $display("FAIL dir%0d err_div0: got %b want %b", i, e, v[i].e); end
      total++; if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d latency: got %0d want %0d", i, lat, v[i].lat); end
      total++; if (bcnt != v[i].lat) begin bad++; $display("FAIL dir%0d busy cycles: got %0d want %0d", i, bcnt, v[i].lat); end
`ifdef ALU_FLAGS_EN
      if (i == 1) begin
        total++; if (fl[0] !== 1'b1) begin bad++; $display("FAIL dir1 V flag: got %b want 1", fl[0]); end
      end
`endif
      // Idle gap so these ops also exercise the IDLE -> EXEC path.
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int lat, bcnt, n;
    logic [15:0] r, er; logic [7:0] rm, erm; logic e, ee; logic [3:0] fl, efl;
    logic [2:0] o; logic [7:0] a, b;
    logic [7:0] corner [4];
    corner[0] = 8'h80; corner[1] = 8'hFF; corner[2] = 8'h00; corner[3] = 8'h7F;
    for (int i = 0; i < 250; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      model(o, a, b, er, erm, ee, n, efl);
      run_op(o, a, b, lat, bcnt, r, rm, e, fl);
      total++; if (r !== er)  begin bad++; $display("FAIL rnd%0d op%0d %h,%h result: got %h want %h", i, o, a, b, r, er); end
      total++; if (rm !== erm) begin bad++; $display("FAIL rnd%0d op%0d %h,%h remainder: got %h want %h", i, o, a, b, rm, erm); end
      total++; if (e !== ee)  begin bad++; $display("FAIL rnd%0d op%0d err_div0: got %b want %b", i, o, e, ee); end
      total++; if (lat != n)  begin bad++; $display("FAIL rnd%0d op%0d latency: got %0d want %0d", i, o, lat, n); end
`ifdef ALU_FLAGS_EN
      total++; if (fl !== efl) begin bad++; $display("FAIL rnd%0d op%0d flags: got %h want %h", i, o, fl, efl); end
`endif
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start = 1'b1; op = 3'd2; in_a = 8'hF9; in_b = 8'h0C;   // -7 * 12
    @(posedge clk); #1;
    // Keep requesting a different op while busy; all of it must be ignored.
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op = 3'd3; in_a = 8'($urandom); in_b = 8'h00;
      @(posedge clk); #1;
    end
    start = 1'b0;
    lat = (done === 1'b1) ? 3 : -1;
    for (int i = 4; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    total++; if (lat != 8)            begin bad++; $display("FAIL busy_ignore latency: got %0d want 8", lat); end
    total++; if (result !== 16'hFFAC) begin bad++; $display("FAIL busy_ignore result: got %h want FFAC", result); end
    total++; if (err_div0 !== 1'b0)   begin bad++; $display("FAIL busy_ignore err_div0: got %b want 0", err_div0); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [15:0] r; logic [7:0] rm; logic e; logic [3:0] fl;
    run_op(3'd3, 8'h05, 8'h00, lat, bcnt, r, rm, e, fl);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL b2b div0 err_div0: got %b want 1", e); end
    // Issued in the DONE cycle: accepted immediately, err_div0 cleared.
    run_op(3'd0, 8'h03, 8'h04, lat, bcnt, r, rm, e, fl);
    total++; if (bcnt != 1)       begin bad++; $display("FAIL b2b add busy cycles: got %0d want 1", bcnt); end
    total++; if (lat != 1)        begin bad++; $display("FAIL b2b add latency: got %0d want 1", lat); end
    total++; if (r !== 16'h0007)  begin bad++; $display("FAIL b2b add result: got %h want 0007", r); end
    total++; if (e !== 1'b0)      begin bad++; $display("FAIL b2b add err_div0: got %b want 0", e); end
    run_op(3'd2, 8'h7F, 8'h80, lat, bcnt, r, rm, e, fl);   // 127 * -128
    total++; if (lat != 8)        begin bad++; $display("FAIL b2b mul latency: got %0d want 8", lat); end
    total++; if (r !== 16'hC080)  begin bad++; $display("FAIL b2b mul result: got %h want C080", r); end
    run_op(3'd3, 8'h64, 8'hF9, lat, bcnt, r, rm, e, fl);   // 100 / -7
    total++; if (lat != 8)        begin bad++; $display("FAIL b2b div latency: got %0d want 8", lat); end
    total++; if (r !== 16'hFFF2)  begin bad++; $display("FAIL b2b div result: got %h want FFF2", r); end
    total++; if (rm !== 8'h02)    begin bad++; $display("FAIL b2b div remainder: got %h want 02", rm); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat, bcnt;
    logic [15:0] r; logic [7:0] rm; logic e; logic [3:0] fl;
    start = 1'b1; op = 3'd3; in_a = 8'h9C; in_b = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_mid done: got %b want 0", done); end
    total++; if (result !== 16'h0)   begin bad++; $display("FAIL rst_mid result: got %h want 0000", result); end
    total++; if (remainder !== 8'h0) begin bad++; $display("FAIL rst_mid remainder: got %h want 00", remainder); end
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid stray done: got %0d pulses want 0", pulses); end
    run_op(3'd0, 8'h01, 8'h02, lat, bcnt, r, rm, e, fl);
    total++; if (r !== 16'h0003) begin bad++; $display("FAIL rst_mid recovery result: got %h want 0003", r); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
